// File: rtl/disk_bus_seq_if.sv
// rtl/disk_bus_seq_if.sv - peripheral bus bundle driven by disk_bus_seq
// Purpose: groups the memory-mapped strobe/address/data signals and the
//          peripheral busy line shared between the sequencer and the bus.
// Signals:
//   mem_write   one-cycle write strobe (master -> slave)
//   mem_read    one-cycle read strobe (master -> slave)
//   addr        bus address (master -> slave)
//   wdata       write data (master -> slave)
//   rdata       read data, valid the cycle after mem_read (slave -> master)
//   periph_busy peripheral busy indication (slave -> master)
interface disk_bus_seq_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              mem_write;
   logic              mem_read;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              periph_busy;

   modport master (
      output mem_write, mem_read, addr, wdata,
      input  rdata, periph_busy
   );

   modport slave (
      input  mem_write, mem_read, addr, wdata,
      output rdata, periph_busy
   );
endinterface

// File: rtl/disk_bus_seq.sv
// rtl/disk_bus_seq.sv - scripted memory-mapped bus driver launched by triggers
// Purpose: each debounced trigger runs its own segment of a script RAM made of
//          WR / RD (with expected-value check) / WAIT (busy poll) / END ops.
//          A sticky error flag records the first read mismatch or poll timeout.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   trig              level trigger requests, lowest index wins
//   prog_we/addr/data script RAM write port, entry = {op, addr, data}
//   bus               master side of the peripheral bus (strobes, addr, data, busy)
//   running           high while a script is executing
//   done              one-cycle pulse when a script ends
//   last_rdata        last captured read data
//   err, err_idx      sticky error flag and script index of the failing entry
module disk_bus_seq #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int NUM_TRIG = 2,
   parameter int SEG_LOG2 = 3,
   parameter int HOLDOFF  = 100000000,
   parameter int TIMEOUT  = 65535
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_TRIG-1:0]                  trig,
   input  logic                                 prog_we,
   input  logic [$clog2(NUM_TRIG)+SEG_LOG2-1:0] prog_addr,
   input  logic [2+ADDR_W+DATA_W-1:0]           prog_data,
   disk_bus_seq_if.master                       bus,
   output logic                                 running,
   output logic                                 done,
   output logic [DATA_W-1:0]                    last_rdata,
   output logic                                 err,
   output logic [$clog2(NUM_TRIG)+SEG_LOG2-1:0] err_idx
);
   localparam int IW    = $clog2(NUM_TRIG) + SEG_LOG2;
   localparam int PW    = 2 + ADDR_W + DATA_W;
   localparam int DEPTH = NUM_TRIG << SEG_LOG2;
   localparam int HW    = $clog2(HOLDOFF + 1);
   localparam int TW    = $clog2(TIMEOUT + 1);

   localparam logic [1:0] OP_WR   = 2'b00;
   localparam logic [1:0] OP_RD   = 2'b01;
   localparam logic [1:0] OP_WAIT = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_RDCHK, S_WAIT, S_DONE} state_t;

   state_t            state, state_nx;
   logic [PW-1:0]     ram [DEPTH];
   logic [PW-1:0]     entry;
   logic [IW-1:0]     pc, pc_nx;
   logic [HW-1:0]     ho_cnt;
   logic [TW-1:0]     wcnt, wcnt_nx;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        e_op;
   logic [ADDR_W-1:0] e_addr;
   logic [DATA_W-1:0] e_data;
   logic              acc, set_err, advance, seg_last, exec_wr, exec_rd;
   logic [IW-1:0]     acc_pc;

   assign e_op     = entry[PW-1 -: 2];
   assign e_addr   = entry[DATA_W +: ADDR_W];
   assign e_data   = entry[DATA_W-1:0];
   assign seg_last = &pc[SEG_LOG2-1:0];
   assign exec_wr  = (state == S_EXEC) && (e_op == OP_WR);
   assign exec_rd  = (state == S_EXEC) && (e_op == OP_RD);

   // Strobes and the current op's address come straight from state so an
   // asynchronous reset removes them in the same cycle.
   assign bus.mem_write = exec_wr;
   assign bus.mem_read  = exec_rd;
   assign bus.addr      = (exec_wr || exec_rd) ? e_addr : addr_q;
   assign bus.wdata     = exec_wr ? e_data : wdata_q;
   assign running       = (state != S_IDLE) && (state != S_DONE);
   assign done          = (state == S_DONE);

   // Scan from the top so the lowest asserted trigger is the one kept.
   always_comb begin
      acc    = 1'b0;
      acc_pc = '0;
      for (int i = NUM_TRIG - 1; i >= 0; i--) begin
         if (trig[i]) begin
            acc    = 1'b1;
            acc_pc = IW'(i) << SEG_LOG2;
         end
      end
      acc = acc && (state == S_IDLE) && (ho_cnt == HW'(HOLDOFF));
   end

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      wcnt_nx  = wcnt;
      set_err  = 1'b0;
      advance  = 1'b0;
      case (state)
         S_IDLE:  if (acc) begin
                     state_nx = S_FETCH;
                     pc_nx    = acc_pc;
                  end
         S_FETCH: state_nx = S_EXEC;
         S_EXEC:  case (e_op)
                     OP_WR:   advance  = 1'b1;
                     OP_RD:   state_nx = S_RDCHK;
                     OP_WAIT: begin
                        // The EXEC cycle is the first poll, so wcnt counts busy polls seen.
                        if (!bus.periph_busy) advance = 1'b1;
                        else if (TIMEOUT <= 1) set_err = 1'b1;
                        else begin
                           wcnt_nx  = TW'(1);
                           state_nx = S_WAIT;
                        end
                     end
                     default: state_nx = S_DONE;
                  endcase
         S_RDCHK: if (bus.rdata != e_data) set_err = 1'b1;
                  else advance = 1'b1;
         S_WAIT:  if (!bus.periph_busy) advance = 1'b1;
                  else if (wcnt == TW'(TIMEOUT - 1)) set_err = 1'b1;
                  else wcnt_nx = wcnt + TW'(1);
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (set_err) state_nx = S_DONE;
      // A segment never wraps: completing its last entry ends the script.
      if (advance) begin
         if (seg_last) state_nx = S_DONE;
         else begin
            state_nx = S_FETCH;
            pc_nx    = pc + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pc         <= '0;
         wcnt       <= '0;
         ho_cnt     <= '0;
         entry      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         last_rdata <= '0;
         err        <= 1'b0;
         err_idx    <= '0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         wcnt  <= wcnt_nx;
         if (acc) ho_cnt <= '0;
         else if (ho_cnt != HW'(HOLDOFF)) ho_cnt <= ho_cnt + HW'(1);
         if (acc) begin
            err     <= 1'b0;
            err_idx <= '0;
         end else if (set_err) begin
            err     <= 1'b1;
            err_idx <= pc;
         end
         if (state == S_FETCH) entry <= ram[pc];
         if (exec_wr || exec_rd) addr_q <= e_addr;
         if (exec_wr) wdata_q <= e_data;
         if (state == S_RDCHK) last_rdata <= bus.rdata;
      end
   end

   // Script RAM is not reset; writes are only taken while no script runs.
   always_ff @(posedge clk) begin
      if (prog_we && !running && (32'(prog_addr) < DEPTH)) ram[prog_addr] <= prog_data;
   end
endmodule
